// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and helpers for the N-to-1 stream multiplexer.
//   MODE_SEL / MODE_RR : selection mode constants
//   idx_w(n)           : width of a channel index for n channels (min 1)
package mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nx1_stream_rr_arbiter.sv
// rr_arbiter: round-robin arbiter over N requesters.
//   clk, rst_n : clock, async active-low reset
//   req        : per-channel request
//   advance    : the current grant was consumed; move pointer past winner
//   grant      : one-hot grant (zero when no request)
//   winner     : index of the granted channel
// The search starts at the pointer and wraps N-1 -> 0. The pointer is owned
// here and only moves on advance.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner
);

  localparam logic [IW:0]   N_L  = (IW+1)'(N);
  localparam logic [IW-1:0] N_M1 = IW'(N - 1);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   idx;
  logic          found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = 0; off < N; off++) begin
      // One extra bit so ptr+off never overflows before the modulo.
      idx = {1'b0, ptr_q} + (IW+1)'(off);
      if (idx >= N_L) idx = idx - N_L;
      if (!found && req[idx[IW-1:0]]) begin
        found                = 1'b1;
        grant[idx[IW-1:0]]   = 1'b1;
        winner               = idx[IW-1:0];
      end
    end
  end

  // Explicit wrap: N need not be a power of two.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = (winner == N_M1) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream: N-to-1 stream multiplexer with a registered output.
//   clk, rst_n        : clock, async active-low reset
//   i / i_valid       : N channels of W-bit data, channel k at [k*W +: W]
//   i_ready           : combinational per-channel ready
//   s                 : channel select (SEL mode only)
//   y / y_valid       : registered output word
//   y_ready           : consumer accepts y
//   y_src             : index of the channel that supplied y
// MODE_SEL decodes the grant from s; MODE_RR uses rr_arbiter.
module mux_nx1_stream
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = MODE_SEL,
  parameter int IW   = idx_w(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] i,
  input  logic [N-1:0]   i_valid,
  output logic [N-1:0]   i_ready,
  input  logic [IW-1:0]  s,
  output logic [W-1:0]   y,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [IW-1:0]  y_src
);

  logic [N-1:0]  grant;
  logic [IW-1:0] winner;
  logic          load, accept;
  logic [W-1:0]  sel_data;

  logic [W-1:0]  y_q, y_d;
  logic          y_valid_q, y_valid_d;
  logic [IW-1:0] y_src_q, y_src_d;

  // The register can refill in the same cycle it drains.
  assign load    = !y_valid_q | y_ready;
  assign accept  = (|grant) & load;
  assign i_ready = grant & {N{load}};

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic unused_s;
      assign unused_s = ^s;
      rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (i_valid),
        .advance (accept),
        .grant   (grant),
        .winner  (winner)
      );
    end else begin : g_sel
      // An out-of-range s matches no channel, so nothing is granted.
      always_comb begin
        grant = '0;
        for (int k = 0; k < N; k++)
          grant[k] = (s == IW'(k)) & i_valid[k];
      end
      assign winner = s;
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++)
      if (grant[k]) sel_data = i[k*W +: W];
  end

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_src_d   = y_src_q;
    if (accept) begin
      y_d       = sel_data;
      y_src_d   = winner;
      y_valid_d = 1'b1;
    end else if (load) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_src_q   <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_src_q   <= y_src_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_src   = y_src_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed bench for mux_nx1_stream: four instances cover SEL N=4, SEL N=3,
// RR N=4 and RR N=5, all W=8.
module tb_mux_nx1_stream;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // d0: SEL N=4
  logic [31:0] i0 = '0; logic [3:0] iv0 = '0, ir0; logic [1:0] s0 = '0;
  logic [7:0] y0; logic yv0, yr0 = 1'b0; logic [1:0] ys0;
  // d1: SEL N=3
  logic [23:0] i1 = '0; logic [2:0] iv1 = '0, ir1; logic [1:0] s1 = '0;
  logic [7:0] y1; logic yv1, yr1 = 1'b0; logic [1:0] ys1;
  // d2: RR N=4
  logic [31:0] i2 = '0; logic [3:0] iv2 = '0, ir2; logic [1:0] s2 = '0;
  logic [7:0] y2; logic yv2, yr2 = 1'b0; logic [1:0] ys2;
  // d3: RR N=5
  logic [39:0] i3 = '0; logic [4:0] iv3 = '0, ir3; logic [2:0] s3 = '0;
  logic [7:0] y3; logic yv3, yr3 = 1'b0; logic [2:0] ys3;

  mux_nx1_stream #(.N(4), .W(8), .MODE(MODE_SEL)) d0 (
    .clk(clk), .rst_n(rst_n), .i(i0), .i_valid(iv0), .i_ready(ir0), .s(s0),
    .y(y0), .y_valid(yv0), .y_ready(yr0), .y_src(ys0));
  mux_nx1_stream #(.N(3), .W(8), .MODE(MODE_SEL)) d1 (
    .clk(clk), .rst_n(rst_n), .i(i1), .i_valid(iv1), .i_ready(ir1), .s(s1),
    .y(y1), .y_valid(yv1), .y_ready(yr1), .y_src(ys1));
  mux_nx1_stream #(.N(4), .W(8), .MODE(MODE_RR)) d2 (
    .clk(clk), .rst_n(rst_n), .i(i2), .i_valid(iv2), .i_ready(ir2), .s(s2),
    .y(y2), .y_valid(yv2), .y_ready(yr2), .y_src(ys2));
  mux_nx1_stream #(.N(5), .W(8), .MODE(MODE_RR)) d3 (
    .clk(clk), .rst_n(rst_n), .i(i3), .i_valid(iv3), .i_ready(ir3), .s(s3),
    .y(y3), .y_valid(yv3), .y_ready(yr3), .y_src(ys3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    // ---- reset state
    #12;
    chk("rst_y",      64'(y0),  64'h0);
    chk("rst_yvalid", 64'(yv0), 64'h0);
    chk("rst_ysrc",   64'(ys0), 64'h0);
    @(negedge clk); rst_n = 1'b1;

    // ---- SEL basic
    @(negedge clk);
    s0 = 2'd2; iv0 = 4'b0100; i0[2*8 +: 8] = 8'hA5; yr0 = 1'b1; #1;
    chk("sel_iready", 64'(ir0), 64'h4);
    after_edge();
    chk("sel_y",      64'(y0),  64'hA5);
    chk("sel_ysrc",   64'(ys0), 64'h2);
    chk("sel_yvalid", 64'(yv0), 64'h1);

    // ---- backpressure: load 11, stall with 22 pending
    @(negedge clk); i0[2*8 +: 8] = 8'h11;
    after_edge();
    chk("bp_load11", 64'(y0), 64'h11);
    @(negedge clk); yr0 = 1'b0; i0[2*8 +: 8] = 8'h22; #1;
    chk("bp_iready0", 64'(ir0), 64'h0);
    after_edge();
    chk("bp_hold_y", 64'(y0), 64'h11);
    // changing s during a stall must not disturb the held word
    @(negedge clk); s0 = 2'd1; iv0 = 4'b0110; i0[1*8 +: 8] = 8'h33; #1;
    chk("bp_s_iready0", 64'(ir0), 64'h0);
    after_edge();
    chk("bp_s_hold_y",   64'(y0),  64'h11);
    chk("bp_s_hold_src", 64'(ys0), 64'h2);
    // ready rises: drain 11 and load 22 in the same cycle
    @(negedge clk); s0 = 2'd2; yr0 = 1'b1; #1;
    chk("bp_hand_iready", 64'(ir0), 64'h4);
    after_edge();
    chk("bp_hand_y",      64'(y0),  64'h22);
    chk("bp_hand_yvalid", 64'(yv0), 64'h1);
    // drain with nothing offered
    @(negedge clk); iv0 = 4'b0000;
    after_edge();
    chk("drain_yvalid", 64'(yv0), 64'h0);

    // ---- SEL invalid select, N=3
    @(negedge clk); s1 = 2'd3; iv1 = 3'b111; i1 = 24'h333231; yr1 = 1'b1; #1;
    chk("inv_iready", 64'(ir1), 64'h0);
    after_edge();
    chk("inv_yvalid", 64'(yv1), 64'h0);
    @(negedge clk); iv1 = 3'b000;

    // ---- RR fairness, N=4
    @(negedge clk);
    i2 = 32'h13121110; iv2 = 4'b1111; yr2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      after_edge();
      chk($sformatf("rr4_src%0d", k), 64'(ys2), 64'(k % 4));
      chk($sformatf("rr4_y%0d", k),   64'(y2),  64'(8'h10 + (k % 4)));
    end
    @(negedge clk); iv2 = 4'b0000;

    // ---- RR skip and wrap, N=5
    @(negedge clk);
    i3 = 40'h5453525150; iv3 = 5'b01000; yr3 = 1'b1; #1;
    chk("rr5_ir_ch3", 64'(ir3), 64'h08);
    after_edge();
    chk("rr5_src3", 64'(ys3), 64'h3);           // p becomes 4
    @(negedge clk); iv3 = 5'b00110; #1;
    chk("rr5_ir_wrap", 64'(ir3), 64'h02);        // search 4,0,1
    after_edge();
    chk("rr5_src_wrap", 64'(ys3), 64'h1);
    chk("rr5_y_wrap",   64'(y3),  64'h51);       // p becomes 2
    @(negedge clk); iv3 = 5'b00010; #1;
    chk("rr5_ir_only1", 64'(ir3), 64'h02);       // search 2,3,4,0,1
    after_edge();
    chk("rr5_src_only1", 64'(ys3), 64'h1);       // p becomes 2 again
    @(negedge clk); yr3 = 1'b0; iv3 = 5'b11111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("rr5_stall_ir%0d", k), 64'(ir3), 64'h0);
      after_edge();
      chk($sformatf("rr5_stall_src%0d", k), 64'(ys3), 64'h1);
      @(negedge clk);
    end
    yr3 = 1'b1; #1;
    chk("rr5_ptr_kept_ir", 64'(ir3), 64'h04);
    after_edge();
    chk("rr5_ptr_kept_src", 64'(ys3), 64'h2);
    chk("rr5_ptr_kept_y",   64'(y3),  64'h52);
    @(negedge clk); iv3 = 5'b00000;

    // ---- reset mid-transfer, between clock edges
    @(negedge clk); s0 = 2'd2; iv0 = 4'b0100; i0[2*8 +: 8] = 8'h5A; yr0 = 1'b0;
    after_edge();
    chk("pre_rst_yvalid", 64'(yv0), 64'h1);
    chk("pre_rst_y",      64'(y0),  64'h5A);
    #2 rst_n = 1'b0; #1;
    chk("async_rst_y",      64'(y0),  64'h0);
    chk("async_rst_yvalid", 64'(yv0), 64'h0);
    chk("async_rst_ysrc",   64'(ys0), 64'h0);
    @(negedge clk); rst_n = 1'b1; iv0 = 4'b0000;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
